// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: pulses the PLL's active-low RESETB, waits for a stable
// lock and then releases the system reset. Lock losses while running pull
// the system back into reset without re-resetting the PLL; a lock that never
// arrives raises a sticky timeout fault and retries the PLL indefinitely.
// Everything runs on the free-running reference clock; the PLL lock flag is
// asynchronous and is only used after a multi-stage synchronizer.
module pll_reset_sequencer #(
    parameter int SYNC_STAGES    = 2,
    parameter int PLL_RST_CYCLES = 8,
    parameter int LOCK_TIMEOUT   = 65536,
    parameter int STABLE_CYCLES  = 1024,
    parameter int HOLD_CYCLES    = 16,
    parameter int LOSS_CNT_W     = 8
) (
    input  logic                  clock_in,
    input  logic                  reset,
    input  logic                  locked,
    input  logic                  clear_status,
    output logic                  pll_resetb,
    output logic                  sys_reset,
    output logic                  sys_ready,
    output logic                  timeout_fault,
    output logic [LOSS_CNT_W-1:0] lock_loss_count
);

    // The shared phase counter only ever needs to reach the longest phase
    // length minus one, so it is sized from the largest timing parameter.
    localparam int MAX_AB  = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_CD  = (STABLE_CYCLES > HOLD_CYCLES) ? STABLE_CYCLES : HOLD_CYCLES;
    localparam int CNT_MAX = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    // Terminal counts: a phase of N cycles ends on the edge where cnt == N-1.
    localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);

    localparam logic [LOSS_CNT_W-1:0] LOSS_SAT = {LOSS_CNT_W{1'b1}};
    localparam logic [LOSS_CNT_W-1:0] LOSS_ONE = LOSS_CNT_W'(1);

    typedef enum logic [2:0] {
        PLL_RST,
        WAIT_LOCK,
        STABILIZE,
        RELEASE,
        RUN
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [CNT_W-1:0]        cnt;
    logic [CNT_W-1:0]        cnt_next;
    logic [SYNC_STAGES-1:0]  sync_ff;
    logic                    locked_s;
    logic                    timeout_evt;
    logic                    loss_evt;

    // Bring the asynchronous lock flag into the reference clock domain.
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            sync_ff <= '0;
        end else begin
            sync_ff <= {sync_ff[SYNC_STAGES-2:0], locked};
        end
    end

    assign locked_s = sync_ff[SYNC_STAGES-1];

    // State and phase counter registers.
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            state <= PLL_RST;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state decision, event strobes and phase counter update.
    always_comb begin
        state_next  = state;
        timeout_evt = 1'b0;
        loss_evt    = 1'b0;
        cnt_next    = cnt;

        unique case (state)
            PLL_RST: begin
                if (cnt == PLL_RST_LAST) begin
                    state_next = WAIT_LOCK;
                end
            end
            WAIT_LOCK: begin
                if (locked_s) begin
                    state_next = STABILIZE;
                end else if (cnt == TIMEOUT_LAST) begin
                    state_next  = PLL_RST;
                    timeout_evt = 1'b1;
                end
            end
            STABILIZE: begin
                if (!locked_s) begin
                    state_next = WAIT_LOCK;
                end else if (cnt == STABLE_LAST) begin
                    state_next = RELEASE;
                end
            end
            RELEASE: begin
                if (!locked_s) begin
                    state_next = WAIT_LOCK;
                end else if (cnt == HOLD_LAST) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (!locked_s) begin
                    state_next = WAIT_LOCK;
                    loss_evt   = 1'b1;
                end
            end
            default: begin
                state_next = PLL_RST;
            end
        endcase

        // Every transition restarts the count; RUN is untimed, so the counter
        // parks there instead of free-running towards a wrap.
        if (state_next != state) begin
            cnt_next = '0;
        end else if (state == RUN) begin
            cnt_next = cnt;
        end else begin
            cnt_next = cnt + CNT_W'(1);
        end
    end

    // Registered outputs derived from the state being entered, so they change
    // on the same edge as the state itself.
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            pll_resetb <= 1'b0;
            sys_reset  <= 1'b1;
            sys_ready  <= 1'b0;
        end else begin
            pll_resetb <= (state_next != PLL_RST);
            sys_reset  <= (state_next != RUN);
            sys_ready  <= !sys_reset && (state_next == RUN);
        end
    end

    // Sticky status: a coincident event always wins over clear_status.
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            timeout_fault   <= 1'b0;
            lock_loss_count <= '0;
        end else begin
            if (timeout_evt) begin
                timeout_fault <= 1'b1;
            end else if (clear_status) begin
                timeout_fault <= 1'b0;
            end

            if (clear_status) begin
                lock_loss_count <= loss_evt ? LOSS_ONE : '0;
            end else if (loss_evt && (lock_loss_count != LOSS_SAT)) begin
                lock_loss_count <= lock_loss_count + LOSS_ONE;
            end
        end
    end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Testbench for pll_reset_sequencer: a phase/duration reference model pushes
// the expected outputs after every clock edge into a queue, and a monitor on
// the falling edge pops and compares them. Directed checks pin down the
// absolute edge timings of the cold start, timeout, relock and async reset.
module tb_pll_reset_sequencer;

    localparam int SS = 2;
    localparam int PR = 3;
    localparam int LT = 20;
    localparam int SC = 4;
    localparam int HC = 2;
    localparam int LW = 2;
    localparam int CNT_SAT = (1 << LW) - 1;

    logic          clock_in = 1'b0;
    logic          reset = 1'b0;
    logic          locked = 1'b0;
    logic          clear_status = 1'b0;
    logic          pll_resetb;
    logic          sys_reset;
    logic          sys_ready;
    logic          timeout_fault;
    logic [LW-1:0] lock_loss_count;

    int errors = 0;
    int checks = 0;

    pll_reset_sequencer #(
        .SYNC_STAGES   (SS),
        .PLL_RST_CYCLES(PR),
        .LOCK_TIMEOUT  (LT),
        .STABLE_CYCLES (SC),
        .HOLD_CYCLES   (HC),
        .LOSS_CNT_W    (LW)
    ) dut (
        .clock_in       (clock_in),
        .reset          (reset),
        .locked         (locked),
        .clear_status   (clear_status),
        .pll_resetb     (pll_resetb),
        .sys_reset      (sys_reset),
        .sys_ready      (sys_ready),
        .timeout_fault  (timeout_fault),
        .lock_loss_count(lock_loss_count)
    );

    always #5 clock_in = ~clock_in;

    typedef struct packed {
        logic          pllrb;
        logic          sysrst;
        logic          ready;
        logic          fault;
        logic [LW-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    // Reference model: the sequence is a list of phases with fixed lengths;
    // the lock flag seen by the sequencer is the input from SS edges earlier.
    typedef enum {PH_PLL, PH_WAIT, PH_STAB, PH_REL, PH_RUN} phase_t;

    phase_t m_ph;
    phase_t m_nph;
    int     m_age;
    int     m_cnt;
    logic   m_fault;
    logic   m_sysrst;
    logic   m_ls;
    logic   m_tmo;
    logic   m_loss;
    logic   lk_hist[$];
    bit     started = 0;
    exp_t   m_e;

    function automatic int phaseLen(input phase_t p);
        case (p)
            PH_PLL:  return PR;
            PH_WAIT: return LT;
            PH_STAB: return SC;
            PH_REL:  return HC;
            default: return 0;
        endcase
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Model update on every edge, reinitialised whenever reset is asserted.
    always @(posedge clock_in or posedge reset) begin
        if (reset) begin
            m_ph     = PH_PLL;
            m_age    = 0;
            m_cnt    = 0;
            m_fault  = 1'b0;
            m_sysrst = 1'b1;
            lk_hist.delete();
            for (int i = 0; i < SS; i++) lk_hist.push_back(1'b0);
            exp_q.delete();
        end else if (started) begin
            m_ls = lk_hist.pop_front();
            lk_hist.push_back(locked);
            m_nph  = m_ph;
            m_tmo  = 1'b0;
            m_loss = 1'b0;
            if (m_ph == PH_RUN) begin
                if (!m_ls) begin
                    m_nph  = PH_WAIT;
                    m_loss = 1'b1;
                end
            end else if (m_ph == PH_PLL) begin
                if (m_age + 1 == phaseLen(m_ph)) m_nph = PH_WAIT;
            end else if (m_ph == PH_WAIT) begin
                if (m_ls) m_nph = PH_STAB;
                else if (m_age + 1 == phaseLen(m_ph)) begin
                    m_nph = PH_PLL;
                    m_tmo = 1'b1;
                end
            end else begin
                if (!m_ls) m_nph = PH_WAIT;
                else if (m_age + 1 == phaseLen(m_ph)) m_nph = (m_ph == PH_STAB) ? PH_REL : PH_RUN;
            end
            m_age = (m_nph != m_ph) ? 0 : m_age + 1;

            if (m_tmo) m_fault = 1'b1;
            else if (clear_status) m_fault = 1'b0;
            if (clear_status) m_cnt = m_loss ? 1 : 0;
            else if (m_loss) m_cnt = (m_cnt + 1 > CNT_SAT) ? CNT_SAT : m_cnt + 1;

            m_e.pllrb  = (m_nph != PH_PLL);
            m_e.sysrst = (m_nph != PH_RUN);
            m_e.ready  = !m_sysrst && (m_nph == PH_RUN);
            m_e.fault  = m_fault;
            m_e.cnt    = LW'(m_cnt);
            m_sysrst   = m_e.sysrst;
            m_ph       = m_nph;
            exp_q.push_back(m_e);
        end
    end

    // Monitor: compare the DUT against the oldest prediction, away from the edge.
    always @(negedge clock_in) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            checkOutput("sb_pll_resetb", int'(pll_resetb), int'(mon_e.pllrb));
            checkOutput("sb_sys_reset", int'(sys_reset), int'(mon_e.sysrst));
            checkOutput("sb_sys_ready", int'(sys_ready), int'(mon_e.ready));
            checkOutput("sb_timeout_fault", int'(timeout_fault), int'(mon_e.fault));
            checkOutput("sb_lock_loss_count", int'(lock_loss_count), int'(mon_e.cnt));
        end
    end

    // Inputs for the next rising edge are driven on the falling edge.
    task automatic applyStimulus(input logic lk, input logic clr);
        @(negedge clock_in);
        locked       = lk;
        clear_status = clr;
    endtask

    // Async reset between edges; outputs must react without a clock edge.
    // Release lands between a falling and a rising edge, so edge 0 follows.
    task automatic doReset(input logic lk);
        @(negedge clock_in);
        #1;
        started      = 1;
        reset        = 1'b1;
        locked       = lk;
        clear_status = 1'b0;
        #1;
        checkOutput("rst_pll_resetb", int'(pll_resetb), 0);
        checkOutput("rst_sys_reset", int'(sys_reset), 1);
        checkOutput("rst_sys_ready", int'(sys_ready), 0);
        checkOutput("rst_timeout_fault", int'(timeout_fault), 0);
        checkOutput("rst_lock_loss_count", int'(lock_loss_count), 0);
        repeat (2) @(negedge clock_in);
        #1;
        reset = 1'b0;
    endtask

    // Called right after reset release with locked held high.
    task automatic checkColdStart();
        repeat (2) @(posedge clock_in);
        #1;
        checkOutput("cold_pllrb_edge1", int'(pll_resetb), 0);
        repeat (2) @(posedge clock_in);
        #1;
        checkOutput("cold_pllrb_edge3", int'(pll_resetb), 1);
        repeat (5) @(posedge clock_in);
        #1;
        checkOutput("cold_sysrst_edge8", int'(sys_reset), 1);
        @(posedge clock_in);
        #1;
        checkOutput("cold_sysrst_edge9", int'(sys_reset), 0);
        checkOutput("cold_ready_edge9", int'(sys_ready), 0);
        @(posedge clock_in);
        #1;
        checkOutput("cold_ready_edge10", int'(sys_ready), 1);
    endtask

    // Drop lock in RUN for a few cycles and relock, optionally clearing
    // status on the very edge the loss is recognised.
    task automatic lossCycle(input logic clr_at_loss);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, clr_at_loss);
        applyStimulus(1'b0, 1'b0);
        for (int i = 0; i < 13; i++) applyStimulus(1'b1, 1'b0);
    endtask

    initial begin
        int  run_len;
        int  cyc;
        logic lv;

        // Cold start with locked tied high.
        doReset(1'b1);
        checkColdStart();
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0);

        // Lock loss in RUN: reset reasserted on the 3rd edge after the fall.
        applyStimulus(1'b0, 1'b0);
        @(posedge clock_in);
        #1;
        checkOutput("loss_sysrst_edge1", int'(sys_reset), 0);
        @(posedge clock_in);
        #1;
        checkOutput("loss_sysrst_edge2", int'(sys_reset), 0);
        @(posedge clock_in);
        #1;
        checkOutput("loss_sysrst_edge3", int'(sys_reset), 1);
        checkOutput("loss_ready_edge3", int'(sys_ready), 0);
        checkOutput("loss_count_first", int'(lock_loss_count), 1);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        repeat (8) @(posedge clock_in);
        #1;
        checkOutput("relock_sysrst_before", int'(sys_reset), 1);
        @(posedge clock_in);
        #1;
        checkOutput("relock_sysrst_release", int'(sys_reset), 0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0);

        // Four more losses saturate the counter; a sixth with clear gives 1.
        for (int i = 0; i < 4; i++) lossCycle(1'b0);
        checkOutput("loss_count_saturated", int'(lock_loss_count), CNT_SAT);
        lossCycle(1'b1);
        checkOutput("loss_count_clear_coincident", int'(lock_loss_count), 1);
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0);
        checkOutput("clear_count", int'(lock_loss_count), 0);
        checkOutput("clear_fault", int'(timeout_fault), 0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0);

        // Async reset mid-RUN, then the cold-start timing repeats.
        doReset(1'b1);
        checkColdStart();
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0);

        // Lock drops for 2 cycles in STABILIZE; release moves to edge 18.
        doReset(1'b0);
        for (int k = 1; k <= 30; k++) begin
            applyStimulus((k >= 4) && (k != 8) && (k != 9), 1'b0);
            if ((k == 17) || (k == 18)) begin
                @(posedge clock_in);
                #1;
                checkOutput("stab_drop_sysrst", int'(sys_reset), (k == 17) ? 1 : 0);
            end
        end
        checkOutput("stab_drop_count", int'(lock_loss_count), 0);

        // Lock stuck low: timeout on edge 22, clear coinciding with edge 45.
        doReset(1'b0);
        repeat (22) @(posedge clock_in);
        #1;
        checkOutput("tmo_fault_edge21", int'(timeout_fault), 0);
        @(posedge clock_in);
        #1;
        checkOutput("tmo_fault_edge22", int'(timeout_fault), 1);
        for (int k = 23; k <= 75; k++) applyStimulus(1'b0, (k == 45) || (k == 50));
        checkOutput("tmo_fault_sticky", int'(timeout_fault), 1);
        checkOutput("tmo_sysrst", int'(sys_reset), 1);
        checkOutput("tmo_ready", int'(sys_ready), 0);

        // Randomised lock behaviour with occasional status clears.
        doReset(1'b1);
        cyc = 0;
        while (cyc < 600) begin
            run_len = $urandom_range(1, 30);
            lv      = 1'($urandom_range(0, 1));
            for (int i = 0; i < run_len; i++) begin
                applyStimulus(lv, ($urandom_range(0, 15) == 0));
                cyc++;
            end
        end
        applyStimulus(1'b1, 1'b0);
        repeat (2) @(negedge clock_in);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Safety net so the run always terminates.
    initial begin
        #300000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
- Supervises the ADC board's PLL and produces the system reset for logic clocked from the PLL output.
- Runs on the stable reference clock and drives the PLL's active-low RESETB.
- Watches the asynchronous `locked` flag. Releases `sys_reset` only after lock has been stable for a programmed time.
- Re-asserts reset on lock loss, and retries the PLL after a lock timeout.

Parameters:
- SYNC_STAGES, 2: flip-flop stages in the `locked` synchronizer (minimum 2).
- PLL_RST_CYCLES, 8: cycles `pll_resetb` is held low per PLL reset pulse (minimum 1).
- LOCK_TIMEOUT, 65536: cycles to wait for lock before a fault and PLL retry (minimum 2).
- STABLE_CYCLES, 1024: consecutive synchronized-locked cycles required before release.
- HOLD_CYCLES, 16: extra cycles `sys_reset` is held after lock is stable.
- LOSS_CNT_W, 8: width of the lock-loss event counter.

Ports:
- clock_in  input  1  reference clock (pre-PLL, always running).
- reset  input  1  asynchronous, active-high reset.
- locked  input  1  PLL lock flag, asynchronous to clock_in.
- clear_status  input  1  synchronous pulse; clears `lock_loss_count` and `timeout_fault`.
- pll_resetb  output  1  to PLL RESETB, active low.
- sys_reset  output  1  active-high system reset; downstream domains re-synchronize it.
- sys_ready  output  1  high while the system is out of reset and locked.
- timeout_fault  output  1  sticky: a lock timeout has occurred.
- lock_loss_count  output  LOSS_CNT_W  saturating count of lock losses while in RUN.

Behaviour:
- Reset is asynchronous and active-high. While reset is asserted, without waiting for a clock edge:
  - state = PLL_RST, all counters = 0, synchronizer flops = 0;
  - pll_resetb = 0, sys_reset = 1, sys_ready = 0, timeout_fault = 0, lock_loss_count = 0.
- `locked_s` is `locked` after SYNC_STAGES flops, giving SYNC_STAGES edges of latency. Only `locked_s` is used.
- A single counter `cnt` is cleared on every state entry. A timed state of N cycles exits on the edge where cnt == N-1.
- All outputs are registered, computed from the next state:
  - pll_resetb = (next != PLL_RST);
  - sys_reset = (next != RUN);
  - sys_ready = the registered sys_reset inverted one cycle later, so it rises one edge after sys_reset falls and falls on the same edge that sys_reset rises.
- States and transitions:
  - PLL_RST: pll_resetb low. Goes to WAIT_LOCK when cnt == PLL_RST_CYCLES-1.
  - WAIT_LOCK:
    - locked_s = 1 → STABILIZE.
    - Otherwise, cnt == LOCK_TIMEOUT-1 → set timeout_fault and go to PLL_RST (retry indefinitely).
  - STABILIZE:
    - locked_s = 0 → WAIT_LOCK, with the timeout count restarting from 0.
    - Otherwise, cnt == STABLE_CYCLES-1 → RELEASE.
  - RELEASE:
    - locked_s = 0 → WAIT_LOCK.
    - Otherwise, cnt == HOLD_CYCLES-1 → RUN.
  - RUN:
    - locked_s = 0 → WAIT_LOCK, and lock_loss_count += 1, saturating at all-ones.
    - No PLL reset is issued on this path.
- Lock drops in STABILIZE or RELEASE are not counted.
- clear_status:
  - Zeroes both status outputs on the next edge.
  - If it coincides with a lock loss in RUN, lock_loss_count becomes 1.
  - If it coincides with a timeout, timeout_fault stays 1. Events are never lost.
- An asynchronous reset mid-sequence returns to PLL_RST immediately. A full sequence follows.
- Counter width is sized for max(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES, HOLD_CYCLES); no wrap-around is possible.

Test Plan:
Bench parameters: SYNC_STAGES=2, PLL_RST_CYCLES=3, LOCK_TIMEOUT=20, STABLE_CYCLES=4, HOLD_CYCLES=2, LOSS_CNT_W=2. Edge 0 is the first rising edge after reset release.
- Cold start, locked tied high:
  - pll_resetb low through edge 2 and high from edge 3.
  - WAIT_LOCK lasts 1 cycle.
  - sys_reset falls on the 10th edge after reset release; sys_ready rises on the 11th.
- locked stuck low:
  - timeout_fault rises on the 23rd edge after reset release.
  - pll_resetb then pulses low for 3 cycles every 23 cycles.
  - sys_reset stays 1 and sys_ready stays 0 throughout.
- locked drops for 2 cycles mid-STABILIZE:
  - Returns to WAIT_LOCK; lock_loss_count stays 0.
  - After relock, STABILIZE restarts its full 4-cycle count.
  - The release edge is delayed accordingly.
- In RUN, locked falls:
  - sys_reset = 1 and sys_ready = 0 on the 3rd edge after the fall.
  - lock_loss_count goes 0 → 1.
  - After relock, sys_reset falls 1+4+2 cycles after locked_s returns high; pll_resetb never pulses.
- Five lock losses in RUN:
  - lock_loss_count saturates at 3.
  - clear_status on the same edge as a 6th loss gives count = 1.
  - clear_status alone gives count = 0 and timeout_fault = 0.
- Assert reset asynchronously mid-RUN, between edges:
  - sys_reset = 1, sys_ready = 0, pll_resetb = 0 immediately, with no clock edge needed.
  - On release, the cold-start timing of scenario 1 repeats.
